// File: rtl/cam_pkg.sv
// Shared constants and types for the camera feature-extraction pipeline.
package cam_pkg;

  localparam int unsigned IMG_W = 640;
  localparam int unsigned IMG_H = 480;
  localparam int unsigned BLK   = 16;
  localparam int unsigned DW    = 12;

  typedef logic [DW-1:0] pixel_t;

  typedef enum logic {EMPTY, READY} bank_state_e;

endpackage

// File: rtl/pool_bank_ram.sv
// Ping-pong feature-map store: one write port, one registered read port.
module pool_bank_ram
  import cam_pkg::*;
#(
  parameter int unsigned Aw = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iWE,
  input  logic [Aw:0]   iWADDR,
  input  logic [DW-1:0] iWDATA,
  input  logic [Aw:0]   iRADDR,
  output logic [DW-1:0] oRDATA
);

  // Bank select is the address MSB; words past OUT_W*OUT_H in each bank stay unused.
  localparam int unsigned Depth = 1 << (Aw + 1);

  pixel_t mem [Depth];
  pixel_t rdata_q;

  always_ff @(posedge iCLK) begin
    if (iWE) begin
      mem[iWADDR] <= iWDATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[iRADDR];
    end
  end

  assign oRDATA = rdata_q;

endmodule

// File: rtl/edge_pool_buffer.sv
// Average-pools the edge-magnitude stream over BLKxBLK blocks into a double-buffered map.
module edge_pool_buffer
  import cam_pkg::*;
#(
  parameter int unsigned  ImgW = IMG_W,
  parameter int unsigned  ImgH = IMG_H,
  parameter int unsigned  Blk  = BLK,
  localparam int unsigned OutW = ImgW / Blk,
  localparam int unsigned OutH = ImgH / Blk,
  localparam int unsigned Aw   = $clog2(OutW * OutH)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSOF,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  output logic          oFRAME_RDY,
  input  logic          iRD_DONE,
  input  logic [Aw-1:0] iRD_ADDR,
  output logic [DW-1:0] oRD_DATA,
  output logic          oOVERRUN,
  output logic [7:0]    oFRAME_CNT
);

  localparam int unsigned LogBlk = $clog2(Blk);
  localparam int unsigned Shift  = 2 * LogBlk;
  localparam int unsigned Sw     = DW + Shift;
  localparam int unsigned Xw     = $clog2(ImgW);
  localparam int unsigned Yw     = $clog2(ImgH);
  localparam int unsigned Cw     = Xw - LogBlk;
  localparam int unsigned Rw     = Yw - LogBlk;

  logic [Xw-1:0] x_q, x_d, x_cur;
  logic [Yw-1:0] y_q, y_d, y_cur;
  logic [Sw-1:0] acc_q [OutW];
  logic [Sw-1:0] acc_d [OutW];
  logic [Sw-1:0] acc_cur, sum;
  logic [Cw-1:0] col;
  logic [Rw-1:0] row;
  logic          blk_done, last_px, we;
  logic [Aw-1:0] wr_addr;
  logic          fc_q, fc_d;

  bank_state_e   state_q, state_d;
  logic          bank_q, bank_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    cnt_q, cnt_d;

  // iSOF makes the coincident pixel (0,0) and sees empty accumulators.
  always_comb begin
    x_cur    = iSOF ? '0 : x_q;
    y_cur    = iSOF ? '0 : y_q;
    col      = x_cur[Xw-1:LogBlk];
    row      = y_cur[Yw-1:LogBlk];
    acc_cur  = iSOF ? '0 : acc_q[col];
    sum      = acc_cur + Sw'(iDATA);
    blk_done = (&x_cur[LogBlk-1:0]) && (&y_cur[LogBlk-1:0]);
    last_px  = (x_cur == Xw'(ImgW - 1)) && (y_cur == Yw'(ImgH - 1));
    we       = iDVAL && blk_done;
    wr_addr  = Aw'(32'(row) * OutW + 32'(col));
    fc_d     = iDVAL && last_px;

    x_d = x_cur;
    y_d = y_cur;
    if (iDVAL) begin
      if (x_cur == Xw'(ImgW - 1)) begin
        x_d = '0;
        y_d = (y_cur == Yw'(ImgH - 1)) ? '0 : y_cur + 1'b1;
      end else begin
        x_d = x_cur + 1'b1;
      end
    end

    acc_d = acc_q;
    if (iSOF) begin
      for (int i = 0; i < OutW; i++) begin
        acc_d[i] = '0;
      end
    end
    if (iDVAL) begin
      acc_d[col] = blk_done ? '0 : sum;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '{default: '0};
      fc_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      fc_q  <= fc_d;
    end
  end

  // bank_q is the write bank; the consumer always reads the other one.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (fc_q) begin
          bank_d  = ~bank_q;
          rdy_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = READY;
        end
      end
      READY: begin
        if (iRD_DONE) begin
          if (fc_q) begin
            bank_d = ~bank_q;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            rdy_d   = 1'b0;
            state_d = EMPTY;
          end
        end else if (fc_q) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= EMPTY;
      bank_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  pool_bank_ram #(
    .Aw (Aw)
  ) u_ram (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iWE    (we),
    .iWADDR ({bank_q, wr_addr}),
    .iWDATA (sum[Sw-1:Shift]),
    .iRADDR ({~bank_q, iRD_ADDR}),
    .oRDATA (oRD_DATA)
  );

  assign oFRAME_RDY = rdy_q;
  assign oOVERRUN   = ovr_q;
  assign oFRAME_CNT = cnt_q;

endmodule

// File: tb/tb_edge_pool_buffer.sv
// Scenario bench for edge_pool_buffer on a reduced 64x48 frame with 16x16 pooling.
module tb_edge_pool_buffer;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int B  = 16;
  localparam int OW = W / B;
  localparam int OH = H / B;
  localparam int NW = OW * OH;
  localparam int AW = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          dval = 1'b0;
  logic          rd_done = 1'b0;
  logic [11:0]   data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          rdy, ovr;
  logic [11:0]   rd_data;
  logic [7:0]    fcnt;

  int checks = 0;
  int errors = 0;
  int ovr_pulses = 0;
  int exp_cnt = 0;
  int sums [NW];
  int model [NW];

  edge_pool_buffer #(
    .ImgW (W),
    .ImgH (H),
    .Blk  (B)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst_n),
    .iSOF       (sof),
    .iDVAL      (dval),
    .iDATA      (data),
    .oFRAME_RDY (rdy),
    .iRD_DONE   (rd_done),
    .iRD_ADDR   (rd_addr),
    .oRD_DATA   (rd_data),
    .oOVERRUN   (ovr),
    .oFRAME_CNT (fcnt)
  );

  always #5 clk = ~clk;

  // Counts high cycles of oOVERRUN, sampled between edges.
  always @(posedge clk) begin
    #2;
    if (ovr === 1'b1) ovr_pulses++;
  end

  // mode 0: constant, 1: x ramp, 2: random. Sums per block are the reference.
  task automatic send_frame(input int mode, input int val, input int lines, input bit gaps);
    for (int i = 0; i < NW; i++) sums[i] = 0;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < W; x++) begin
        int d;
        if (gaps && $urandom_range(0, 7) == 0) begin
          @(negedge clk);
          sof  = 1'b0;
          dval = 1'b0;
        end
        case (mode)
          0:       d = val;
          1:       d = x % 4096;
          default: d = int'($urandom_range(0, 4095));
        endcase
        @(negedge clk);
        sof  = (x == 0 && y == 0);
        dval = 1'b1;
        data = 12'(d);
        sums[(y / B) * OW + x / B] += d;
      end
    end
  endtask

  task automatic finish_frame(input bit done_at_fc, input bit rdy_before, input bit rdy_after,
                              input string name);
    @(negedge clk);
    dval    = 1'b0;
    sof     = 1'b0;
    rd_done = done_at_fc;
    checks++;
    if (rdy !== rdy_before) begin
      errors++;
      $display("FAIL %s rdy_at_fc got %b want %b", name, rdy, rdy_before);
    end
    @(negedge clk);
    rd_done = 1'b0;
    checks++;
    if (rdy !== rdy_after) begin
      errors++;
      $display("FAIL %s rdy_after_fc got %b want %b", name, rdy, rdy_after);
    end
  endtask

  task automatic check_reads(input string name);
    for (int a = 0; a < NW; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      @(negedge clk);
      checks++;
      if (rd_data !== 12'(model[a])) begin
        errors++;
        $display("FAIL %s read[%0d] got %0d want %0d", name, a, rd_data, model[a]);
      end
    end
  endtask

  task automatic check_status(input string name, input int exp_ovr);
    checks++;
    if (fcnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d want %0d", name, fcnt, exp_cnt);
    end
    checks++;
    if (ovr_pulses != exp_ovr) begin
      errors++;
      $display("FAIL %s overrun_cycles got %0d want %0d", name, ovr_pulses, exp_ovr);
    end
  endtask

  task automatic release_bank(input string name);
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s rdy_after_release got %b want 0", name, rdy);
    end
  endtask

  task automatic fill_model(input int val);
    for (int i = 0; i < NW; i++) model[i] = val;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (rdy !== 1'b0 || ovr !== 1'b0 || rd_data !== 12'd0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL %s outputs got rdy=%b ovr=%b data=%0d cnt=%0d want all 0",
               name, rdy, ovr, rd_data, fcnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant();
    ovr_pulses = 0;
    send_frame(0, 100, H, 1'b0);
    finish_frame(1'b0, 1'b0, 1'b1, "constant");
    exp_cnt++;
    fill_model(100);
    check_status("constant", 0);
    check_reads("constant");
  endtask

  task automatic test_ramp();
    release_bank("ramp");
    send_frame(1, 0, H, 1'b0);
    finish_frame(1'b0, 1'b0, 1'b1, "ramp");
    exp_cnt++;
    for (int a = 0; a < NW; a++) model[a] = 16 * (a % OW) + 7;
    check_status("ramp", 0);
    check_reads("ramp");
  endtask

  task automatic test_overrun();
    ovr_pulses = 0;
    send_frame(2, 0, H, 1'b1);
    finish_frame(1'b0, 1'b1, 1'b1, "overrun");
    repeat (3) @(negedge clk);
    check_status("overrun", 1);
    check_reads("overrun_keeps_old");
  endtask

  task automatic test_back_to_back();
    ovr_pulses = 0;
    send_frame(0, 50, H, 1'b0);
    finish_frame(1'b1, 1'b1, 1'b1, "done_at_fc");
    exp_cnt++;
    fill_model(50);
    check_status("done_at_fc", 0);
    check_reads("done_at_fc");
  endtask

  task automatic test_random();
    ovr_pulses = 0;
    release_bank("random");
    send_frame(2, 0, H, 1'b1);
    finish_frame(1'b0, 1'b0, 1'b1, "random");
    exp_cnt++;
    for (int a = 0; a < NW; a++) model[a] = sums[a] / (B * B);
    check_status("random", 0);
    check_reads("random");
  endtask

  task automatic test_sof_abort();
    release_bank("sof_abort");
    ovr_pulses = 0;
    send_frame(0, 200, 40, 1'b0);
    @(negedge clk);
    dval = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL sof_abort early_rdy got %b want 0", rdy);
    end
    send_frame(0, 30, H, 1'b0);
    finish_frame(1'b0, 1'b0, 1'b1, "sof_abort");
    exp_cnt++;
    fill_model(30);
    check_status("sof_abort", 0);
    check_reads("sof_abort");
  endtask

  task automatic test_reset_mid();
    send_frame(0, 7, 20, 1'b0);
    @(negedge clk);
    dval = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    ovr_pulses = 0;
    send_frame(0, 7, H, 1'b0);
    finish_frame(1'b0, 1'b0, 1'b1, "after_reset");
    exp_cnt++;
    fill_model(7);
    check_status("after_reset", 0);
    check_reads("after_reset");
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_overrun();
    test_back_to_back();
    test_random();
    test_sof_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_pool_buffer.md
Name: edge_pool_buffer

Overview:
Downstream of the Sobel edge-magnitude stage.
- Consumes the 12-bit edge-magnitude stream (raster order, 640x480, qualified by a valid strobe).
- Average-pools it over non-overlapping BLK x BLK blocks into a 40x30 feature map.
- Stores the map in a double-buffered (ping-pong) RAM.
- Hands complete frames to the NN input stage through a ready/done handshake and a random-access read port.

Parameters:
- IMG_W, 640, input frame width in pixels (multiple of BLK).
- IMG_H, 480, input frame height in lines (multiple of BLK).
- BLK, 16, pooling block edge; power of two.
- DW, 12, pixel/result data width.
- Derived:
  - OUT_W = IMG_W/BLK = 40
  - OUT_H = IMG_H/BLK = 30
  - SHIFT = 2*log2(BLK) = 8
  - AW = 11 (address width; 1200 words)
  - SW = DW+SHIFT = 20

Ports:
- iCLK, in, 1, clock.
- iRST, in, 1, asynchronous, active-low reset.
- iSOF, in, 1, start-of-frame pulse; restarts position counters.
- iDVAL, in, 1, pixel valid from edge stage.
- iDATA, in, DW, unsigned edge magnitude.
- oFRAME_RDY, out, 1, read bank holds a complete pooled frame.
- iRD_DONE, in, 1, one-cycle pulse from consumer releasing the read bank.
- iRD_ADDR, in, AW, read address = row*OUT_W + col.
- oRD_DATA, out, DW, pooled value; registered, 1-cycle latency.
- oOVERRUN, out, 1, one-cycle pulse when a completed frame is dropped.
- oFRAME_CNT, out, 8, count of frames published; wraps at 255.

Behaviour:

Reset (iRST low, asynchronous):
- x/y counters = 0; all accumulators = 0; write bank = 0.
- State EMPTY.
- oFRAME_RDY = 0, oRD_DATA = 0, oOVERRUN = 0, oFRAME_CNT = 0.
- RAM contents are undefined after reset.

Position tracking:
- x (0..IMG_W-1) increments on each cycle with iDVAL high.
- At x = IMG_W-1, x wraps to 0 and y increments.
- At the last pixel (x = IMG_W-1, y = IMG_H-1), both wrap to 0.

iSOF:
- Forces x = y = 0 and clears all accumulators. The partial frame is discarded with no publish and no overrun.
- If iSOF and iDVAL are high in the same cycle, that pixel is treated as pixel (0,0).

Accumulation:
- Row of OUT_W accumulators, each SW bits wide; column index c = x>>log2(BLK).
- On a valid pixel, sum = acc[c] + iDATA, evaluated combinationally.
- Block-complete condition: x%BLK == BLK-1 and y%BLK == BLK-1.
  - If block-complete: write sum>>SHIFT (truncating mean) to write-bank address (y>>log2 BLK)*OUT_W + c, and set acc[c] = 0.
  - Otherwise: acc[c] = sum.
- Overflow is impossible: max 256*4095 = 1048320 < 2^20.

Frame complete:
- Occurs on the cycle after the last pixel is accepted (the registered event FC).

Bank FSM:
- EMPTY:
  - On FC: swap banks (read bank := just-written bank), oFRAME_RDY = 1, oFRAME_CNT++, go to READY.
  - iRD_DONE has no effect.
- READY:
  - iRD_DONE without FC: oFRAME_RDY = 0, go to EMPTY.
  - FC without iRD_DONE: drop the frame (no swap), pulse oOVERRUN, stay in READY. The write bank is overwritten by the next frame.
  - FC and iRD_DONE in the same cycle: release takes priority. Swap, oFRAME_CNT++, stay in READY, oFRAME_RDY stays 1, no overrun.

Timing:
- oFRAME_RDY rises 2 cycles after the last pixel's iDVAL cycle (1 cycle to RAM write/FC, 1 cycle to state update).
- Read port: oRD_DATA = read_bank[iRD_ADDR], registered. It is valid in any state; its contents are meaningful only while oFRAME_RDY = 1.
- iRD_ADDR >= OUT_W*OUT_H returns don't-care.
- No back-pressure toward the edge stage: input is accepted every iDVAL cycle unconditionally.

Decomposition:
- Shared package cam_pkg holds:
  - constants IMG_W, IMG_H, DW
  - typedef pixel_t (logic [DW-1:0])
  - bank FSM enum {EMPTY, READY}
- Sub-module pool_bank_ram: simple dual-port RAM, 2*OUT_W*OUT_H x DW, one write port, one registered read port. The bank select is the address MSB, so the RAM infers as block RAM.

Test Plan:
1. Reset, then a constant frame with iDATA = 100 -> oFRAME_RDY rises 2 cycles after the last pixel; all 1200 addresses read 100; oFRAME_CNT = 1.
2. Frame with iDATA = x (mod 4096) -> address r*40+c reads 16c+7 for every row r (truncation check: mean 16c+7.5 -> 16c+7).
3. Two frames back-to-back with no iRD_DONE -> second FC pulses oOVERRUN for exactly 1 cycle; reads still return frame-1 data; oFRAME_CNT stays 1.
4. Hold iRD_DONE high on the exact FC cycle of frame 2 (frame 1 = 100s, frame 2 = 50s) -> no oOVERRUN; oFRAME_RDY stays 1; reads return 50; oFRAME_CNT = 2.
5. iSOF after 320 lines of a frame of 200s, followed by a full frame of 30s -> published frame reads 30 everywhere; no overrun; no early oFRAME_RDY.
6. Assert iRST low mid-frame while in READY -> oFRAME_RDY, oOVERRUN, oRD_DATA and oFRAME_CNT go to 0 immediately (asynchronously); a subsequent full frame of 7s publishes correctly.
